// File: rtl/fc_par_mac_pkg.sv
// Shared definitions for the fully-connected compute core: FSM encoding,
// default datapath widths and int8 output limits.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_e;

  localparam int FC_DATA_W  = 8;
  localparam int FC_ACC_W   = 32;
  localparam int FC_LEN_W   = 12;
  localparam int FC_SHIFT_W = 5;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

endpackage

// File: rtl/fc_par_mac_if.sv
// Streaming ports of the FC core: input beats (feature + per-channel weights)
// and the requantised result stream.
interface fc_par_mac_if
  import fc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = FC_DATA_W
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   in_feat;
  logic [NUM_CH*DATA_W-1:0]   in_wgt;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [DATA_W-1:0]   out_data;
  logic                       out_last;

  modport slave (
    input  in_valid, in_feat, in_wgt, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_feat, in_wgt, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fc_par_mac_requant.sv
// Requantisation of one accumulator: arithmetic right shift, optional ReLU,
// then saturation to the signed output width.
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_W   = FC_ACC_W,
  parameter int DATA_W  = FC_DATA_W,
  parameter int SHIFT_W = FC_SHIFT_W
) (
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic        [SHIFT_W-1:0] i_shift,
  input  logic                      i_relu,
  output logic signed [DATA_W-1:0]  o_q
);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return SAT_HI[DATA_W-1:0];
    else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
    else                 return v[DATA_W-1:0];
  endfunction

  logic signed [ACC_W-1:0] w_shr;
  logic signed [ACC_W-1:0] w_rel;

  always_comb begin
    w_shr = i_acc >>> i_shift;
    w_rel = (i_relu && (w_shr < 0)) ? '0 : w_shr;
    o_q   = sat(w_rel);
  end

endmodule

// File: rtl/fc_par_mac.sv
// Fully-connected core: NUM_CH parallel MAC accumulators over a streamed input
// vector, drained one channel per handshake through a shared requantiser.
module fc_par_mac
  import fc_pkg::*;
#(
  parameter  int NUM_CH  = 4,
  parameter  int DATA_W  = FC_DATA_W,
  parameter  int ACC_W   = FC_ACC_W,
  parameter  int LEN_W   = FC_LEN_W,
  parameter  int SHIFT_W = FC_SHIFT_W,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [LEN_W-1:0]          in_len,
  input  logic [NUM_CH*ACC_W-1:0]   bias,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      done,
  output logic [IDX_W-1:0]          max_index,
  fc_par_mac_if.slave               bus
);

  function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DATA_W-1:0] f,
                                                       input logic signed [DATA_W-1:0] w);
    logic signed [2*DATA_W-1:0] p;
    p = f * w;
    return ACC_W'(p);
  endfunction

  fc_state_e                r_state, w_state_d;
  logic [LEN_W-1:0]         r_len, r_cnt;
  logic [SHIFT_W-1:0]       r_shift, w_shift;
  logic                     r_relu, w_relu;
  logic [IDX_W-1:0]         r_ptr, w_ptr_d, r_best_idx, w_win_idx, r_max_index;
  logic signed [DATA_W-1:0] r_best_val, r_out_data, w_req;
  logic signed [ACC_W-1:0]  r_acc [NUM_CH];
  logic signed [ACC_W-1:0]  w_acc_d [NUM_CH];
  logic signed [ACC_W-1:0]  w_req_acc;
  logic r_in_ready, r_out_valid, r_out_last, r_busy, r_done;
  logic w_start, w_load, w_beat, w_out_hs, w_last_ch, w_take;

  assign w_start   = (r_state == IDLE) && start;
  assign w_beat    = (r_state == ACC) && bus.in_valid;
  assign w_out_hs  = r_out_valid && bus.out_ready;
  assign w_last_ch = (r_ptr == IDX_W'(NUM_CH-1));
  assign w_take    = (r_ptr == '0) || (r_out_data > r_best_val);
  assign w_win_idx = w_take ? r_ptr : r_best_idx;

  // Requant settings are still on the input pins during the start cycle.
  assign w_shift   = (r_state == IDLE) ? shift   : r_shift;
  assign w_relu    = (r_state == IDLE) ? relu_en : r_relu;
  assign w_req_acc = w_acc_d[w_ptr_d];

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_load    = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_ptr_d = '0;
        if (in_len == '0) begin
          w_state_d = DRAIN;
          w_load    = 1'b1;
        end else begin
          w_state_d = ACC;
        end
      end
      ACC: if (w_beat && (r_cnt == r_len - LEN_W'(1))) begin
        w_state_d = DRAIN;
        w_ptr_d   = '0;
        w_load    = 1'b1;
      end
      DRAIN: if (w_out_hs) begin
        if (w_last_ch) begin
          w_state_d = DONE;
        end else begin
          w_ptr_d = r_ptr + IDX_W'(1);
          w_load  = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  // MAC array: next accumulator values feed both the registers and the
  // requantiser, so channel 0 is ready the cycle after the last beat.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      w_acc_d[k] = r_acc[k];
      if (w_start)
        w_acc_d[k] = bias[k*ACC_W +: ACC_W];
      else if (w_beat)
        w_acc_d[k] = r_acc[k] + mac_term(bus.in_feat, bus.in_wgt[k*DATA_W +: DATA_W]);
    end
  end

  fc_requant #(
    .ACC_W   (ACC_W),
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .i_acc   (w_req_acc),
    .i_shift (w_shift),
    .i_relu  (w_relu),
    .o_q     (w_req)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_relu      <= 1'b0;
      r_out_data  <= '0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_max_index <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) r_acc[k] <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_in_ready  <= (w_state_d == ACC);
      r_out_valid <= (w_state_d == DRAIN);
      r_out_last  <= (w_state_d == DRAIN) && (w_ptr_d == IDX_W'(NUM_CH-1));
      r_busy      <= (w_state_d != IDLE);
      r_done      <= (w_state_d == DONE);
      for (int k = 0; k < NUM_CH; k++) r_acc[k] <= w_acc_d[k];
      if (w_start) begin
        r_len   <= in_len;
        r_shift <= shift;
        r_relu  <= relu_en;
        r_cnt   <= '0;
      end else if (w_beat) begin
        r_cnt   <= r_cnt + LEN_W'(1);
      end
      if (w_load) r_out_data <= w_req;
      // Running argmax over emitted values; strict compare keeps the lowest index on ties.
      if (w_out_hs) begin
        if (w_take) r_best_val <= r_out_data;
        r_best_idx <= w_win_idx;
        if (w_last_ch) r_max_index <= w_win_idx;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign busy          = r_busy;
  assign done          = r_done;
  assign max_index     = r_max_index;

endmodule

// File: tb/tb_fc_par_mac.sv
// Directed bench for fc_par_mac (NUM_CH=4): hand-computed outputs, argmax,
// latency, backpressure, stray start and mid-run reset.
module tb_fc_par_mac;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int LW  = 12;
  localparam int SW  = 5;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [LW-1:0]     in_len;
  logic [NCH*AW-1:0] bias;
  logic [SW-1:0]     shift;
  logic              relu_en;
  logic              busy, done;
  logic [IW-1:0]     max_index;

  fc_par_mac_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  fc_par_mac #(
    .NUM_CH(NCH), .DATA_W(DW), .ACC_W(AW), .LEN_W(LW), .SHIFT_W(SW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .in_len    (in_len),
    .bias      (bias),
    .shift     (shift),
    .relu_en   (relu_en),
    .busy      (busy),
    .done      (done),
    .max_index (max_index),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  logic signed [DW-1:0] feat_v [8];
  logic signed [DW-1:0] wgt_v  [8][NCH];
  int bias_v [NCH];
  int exp_v  [NCH];
  int st_ch, st_n;
  bit stray;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tot++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setv(input int f0, input int f1, input int f2,
                      input int w0, input int w1, input int w2, input int w3);
    feat_v[0] = DW'(f0); feat_v[1] = DW'(f1); feat_v[2] = DW'(f2);
    for (int i = 0; i < 8; i++) begin
      wgt_v[i][0] = DW'(w0); wgt_v[i][1] = DW'(w1);
      wgt_v[i][2] = DW'(w2); wgt_v[i][3] = DW'(w3);
    end
  endtask

  task automatic setb(input int b0, input int b1, input int b2, input int b3);
    bias_v[0] = b0; bias_v[1] = b1; bias_v[2] = b2; bias_v[3] = b3;
  endtask

  task automatic sete(input int e0, input int e1, input int e2, input int e3);
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2; exp_v[3] = e3;
  endtask

  // cyc counts cycles inclusively: the cycle carrying start is 1, so with no
  // stalls the cycle showing done must be in_len + NCH + 2.
  task automatic run(input string nm, input int len, input int sh, input bit rl, input int exp_idx);
    int cyc, to;
    logic signed [DW-1:0] held;
    @(negedge clk);
    start = 1'b1; in_len = LW'(len); shift = SW'(sh); relu_en = rl;
    for (int k = 0; k < NCH; k++) bias[k*AW +: AW] = AW'(bias_v[k]);
    cyc = 1;
    @(negedge clk); cyc++; start = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    if (len > 0) chk({nm, "_rdy"}, bus.in_ready, 1);
    for (int i = 0; i < len; i++) begin
      bus.in_valid = 1'b1;
      bus.in_feat  = feat_v[i];
      for (int k = 0; k < NCH; k++) bus.in_wgt[k*DW +: DW] = wgt_v[i][k];
      if (stray && i == 1) begin start = 1'b1; in_len = LW'(1); shift = SW'(3); end
      @(negedge clk); cyc++;
      start = 1'b0; in_len = LW'(len); shift = SW'(sh);
    end
    bus.in_valid = 1'b0;
    chk({nm, "_vld_first"}, bus.out_valid, 1);
    for (int c = 0; c < NCH; c++) begin
      to = 0;
      while (!bus.out_valid && to < 20) begin @(negedge clk); cyc++; to++; end
      if (to >= 20) chk({nm, "_vld_timeout"}, bus.out_valid, 1);
      chk($sformatf("%s_ch%0d_data", nm, c), bus.out_data, exp_v[c]);
      chk($sformatf("%s_ch%0d_last", nm, c), bus.out_last, (c == NCH-1));
      if (c == st_ch && st_n > 0) begin
        held = bus.out_data;
        bus.out_ready = 1'b0;
        for (int s = 0; s < st_n; s++) begin
          if (stray && s == 1) begin start = 1'b1; in_len = LW'(1); end
          @(negedge clk); cyc++;
          start = 1'b0; in_len = LW'(len);
          chk({nm, "_stall_vld"}, bus.out_valid, 1);
          chk({nm, "_stall_data"}, bus.out_data, held);
          chk({nm, "_stall_last"}, bus.out_last, 0);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk); cyc++;
    end
    chk({nm, "_done"}, done, 1);
    chk({nm, "_vld_end"}, bus.out_valid, 0);
    chk({nm, "_maxidx"}, max_index, exp_idx);
    if (st_n == 0) chk({nm, "_latency"}, cyc, len + NCH + 2);
    @(negedge clk);
    chk({nm, "_done_1cyc"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b1; start = 1'b0; in_len = '0; bias = '0; shift = '0; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_feat = '0; bus.in_wgt = '0; bus.out_ready = 1'b1;
    st_ch = -1; st_n = 0; stray = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_vld", bus.out_valid, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_maxidx", max_index, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // 1: plain sum of 1+2+3 on every channel
    setv(1, 2, 3, 1, 1, 1, 1); setb(0, 0, 0, 0); sete(6, 6, 6, 6);
    run("c1", 3, 0, 1'b0, 0);

    // 2: mixed-sign weights, with and without ReLU
    setv(10, 20, 0, 1, -1, 2, 0); sete(30, 0, 60, 0);
    run("c2_relu", 2, 0, 1'b1, 2);
    sete(30, -30, 60, 0);
    run("c2_norelu", 2, 0, 1'b0, 2);

    // 3: 127*127*2 = 32258 saturates; >>8 gives 126; with -70000 bias -> -128
    setv(127, 127, 0, 127, 127, 127, 127); sete(127, 127, 127, 127);
    run("c3_sat", 2, 0, 1'b0, 0);
    sete(126, 126, 126, 126);
    run("c3_shift", 2, 8, 1'b0, 0);
    setb(-70000, -70000, -70000, -70000); sete(-128, -128, -128, -128);
    run("c3_neg", 2, 0, 1'b0, 0);

    // 4: zero-length run emits requantised bias; tie on 9 picks index 2
    setb(5, -3, 9, 9); sete(5, -3, 9, 9);
    run("c4_len0", 0, 0, 1'b0, 2);

    // 5: distinct channels, channel 1 stalled 3 cycles, stray starts in ACC and DRAIN
    setv(1, 2, 3, 1, 2, 3, 4); setb(0, 0, 0, 0); sete(6, 12, 18, 24);
    st_ch = 1; st_n = 3; stray = 1'b1;
    run("c5_bp", 3, 0, 1'b0, 3);
    st_ch = -1; st_n = 0; stray = 1'b0;

    // 6: reset after 2 of 5 beats, then a fresh run
    setv(1, 2, 3, 1, 1, 1, 1);
    feat_v[3] = DW'(4); feat_v[4] = DW'(5);
    @(negedge clk);
    start = 1'b1; in_len = LW'(5); bias = '0; shift = '0; relu_en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_feat = feat_v[i];
      for (int k = 0; k < NCH; k++) bus.in_wgt[k*DW +: DW] = wgt_v[i][k];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("c6_busy", busy, 0);
    chk("c6_rdy", bus.in_ready, 0);
    chk("c6_vld", bus.out_valid, 0);
    chk("c6_data", bus.out_data, 0);
    chk("c6_maxidx", max_index, 0);
    chk("c6_done", done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("c6_no_done", done, 0);
    end
    sete(6, 6, 6, 6);
    run("c6_rerun", 3, 0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_par_mac.md
# fc_par_mac

Parametrised fully-connected compute core that evaluates NUM_CH output neurons in parallel over a streamed input vector. It replaces the fixed single-configuration FC datapath under the FC top level. Per-run configuration comes from the APB register block: input length, per-channel bias, requantisation shift and ReLU enable. Results stream out as requantised int8 values, and the argmax index is latched for APB readback.

## Interface

- NUM_CH, 4, output channels computed in parallel (1..16)
- DATA_W, 8, signed feature/weight/output width
- ACC_W, 32, signed accumulator width
- LEN_W, 12, width of input-length field
- SHIFT_W, 5, width of requant shift field
- clk  input  1  single clock, all logic rising-edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  one-cycle run request; sampled only in IDLE
- in_len  input  LEN_W  number of input elements; captured at start
- bias  input  NUM_CH*ACC_W  signed per-channel bias; channel k at bits [k*ACC_W +: ACC_W]; captured at start
- shift  input  SHIFT_W  arithmetic right-shift amount; captured at start
- relu_en  input  1  clamp negatives to 0; captured at start
- in_valid  input  1  input beat valid
- in_ready  output  1  core accepts a beat
- in_feat  input  DATA_W  signed feature element
- in_wgt  input  NUM_CH*DATA_W  signed weight for each channel for this element; channel k at [k*DATA_W +: DATA_W]
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  DATA_W  requantised result for the current channel
- out_last  output  1  high with channel NUM_CH-1
- busy  output  1  high outside IDLE
- done  output  1  one-cycle pulse at run completion
- max_index  output  $clog2(NUM_CH) (min 1)  argmax of the last run

## Operation

- States: IDLE, ACC, DRAIN, DONE.
- IDLE -> ACC on start: acc[k] <= bias[k], beat counter <= 0, and in_len/shift/relu_en are captured.
- IDLE -> DRAIN directly on start when in_len == 0; the outputs are then the requantised bias values.
- ACC: in_ready = 1. On each handshake, acc[k] += sext(in_feat * in_wgt[k]) for every k, and the counter increments. The beat with counter == in_len-1 moves the core to DRAIN.
- Accumulation wraps modulo 2^ACC_W. There is no saturation inside the accumulator.
- DRAIN: channels are emitted in order 0..NUM_CH-1, one per out handshake. out_last is set with channel NUM_CH-1, and its handshake moves the core to DONE.
- Requant, per channel:
  - r = acc >>> shift (arithmetic; truncation toward -inf).
  - If relu_en and r < 0, then r = 0.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Argmax: computed over the requantised values as they are emitted. A strictly greater value replaces the current winner, so ties resolve to the lowest index. max_index updates in DONE and holds until the next DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. It is neither queued nor allowed to disturb the run.
- in_valid outside ACC is ignored (in_ready = 0).

## Timing

- Reset values:
  - state = IDLE; in_ready, out_valid, out_last, busy and done = 0.
  - out_data = 0, max_index = 0, all accumulators = 0.
- Reset asserted mid-run aborts the run immediately. There is no done pulse, and the next start behaves as a fresh run.
- start sampled at edge t: busy = 1 and in_ready = 1 from cycle t+1.
- Input throughput is one beat per cycle. Stalls follow in_valid only.
- The cycle after the last input handshake shows out_valid = 1 with channel 0. All outputs are registered.
- out_valid stalled: out_data and out_last hold stable while out_valid = 1 and out_ready = 0. out_valid never drops without a handshake.
- done is high the cycle after the final out handshake, and IDLE follows. start is accepted again in that IDLE cycle.
- Minimum start-to-done latency with no stalls is in_len + NUM_CH + 2 cycles.

## Structure

- Shared package fc_pkg holds:
  - the state enum (IDLE/ACC/DRAIN/DONE);
  - default widths for DATA_W, ACC_W, LEN_W and SHIFT_W;
  - the int8 saturation limits.
- Sub-module fc_requant: combinational shift, ReLU and saturate on one accumulator. The core instantiates one copy on the channel selected by the drain pointer.
- The MAC array is a generate loop of NUM_CH accumulators in the core itself. No per-channel sub-module is needed.

## Test plan

Bench uses NUM_CH=4 with default widths.

1. in_len=3, features 1,2,3, all weights 1, bias 0, shift 0, relu off -> outputs 6,6,6,6; out_last on the 4th; max_index=0; done 1 cycle after the last handshake.
2. in_len=2, features 10,20, channel weights {1,-1,2,0}, bias 0, relu on -> outputs 30,0,60,0; max_index=2. Same run with relu off -> 30,-30,60,0.
3. in_len=2, features 127,127, weights 127, bias 0:
   - shift 0 -> all 127 (saturated from 32258);
   - shift 8 -> all 126;
   - bias -70000, relu off, shift 0 -> all -128.
4. in_len=0, bias {5,-3,9,9}, shift 0 -> outputs 5,-3,9,9; max_index=2 (tie goes to the lower index); done at start+NUM_CH+2 cycles.
5. Backpressure and stray start: out_ready low for 3 cycles while channel 1 is valid, and start pulsed during ACC and DRAIN -> channel 1 data is held stable, no duplicate or dropped outputs, and the stray start has no effect.
6. rstn pulsed low after 2 of 5 input beats -> all outputs 0 immediately with no done pulse. A new run from case 1 then produces 6,6,6,6.
